// File: rtl/sharp_frame_sequencer.sv
// Frame sequencer for the LS013B7DH01 memory LCD: walks lines from the framebuffer into the line transmitter.
// Define SHARP_EXTCOMIN_EN for hardware VCOM (EXTCOMIN pin); otherwise VCOM travels in the M1 mode bit.
module sharp_frame_sequencer #(
  parameter int NUM_LINES = 168,
  parameter int LINE_BITS = 144,
  parameter int VCOM_DIV  = 200000
) (
  input  logic                 clk_12mhz,
  input  logic                 rst,
  input  logic                 frame_req,
  input  logic                 clear_req,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic [7:0]           fb_addr,
  output logic                 fb_rd,
  input  logic [LINE_BITS-1:0] fb_data,
  output logic                 tx_start,
  output logic [2:0]           tx_mode,
  output logic [7:0]           tx_addr,
  output logic [LINE_BITS-1:0] tx_data,
  input  logic                 tx_busy,
  output logic                 vcom
);

  localparam int VW = (VCOM_DIV > 1) ? $clog2(VCOM_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX,
    S_CLEAR_SEND,
    S_CLEAR_WAIT,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [7:0]             r_line;
  logic                   r_wait_first;
  logic                   r_frame_pend;
  logic                   r_clear_pend;
  logic [LINE_BITS-1:0]   r_line_buf;
  logic [VW-1:0]          r_vcnt;
  logic                   r_vcom_state;

  logic                   r_frame_busy;
  logic                   r_frame_done;
  logic [7:0]             r_fb_addr;
  logic                   r_fb_rd;
  logic                   r_tx_start;
  logic [2:0]             r_tx_mode;
  logic [7:0]             r_tx_addr;
  logic [LINE_BITS-1:0]   r_tx_data;

  logic                   w_frame_pend;
  logic                   w_clear_pend;
  logic                   w_accept_frame;
  logic                   w_accept_clear;
  logic                   w_fire_line;
  logic                   w_fire_clear;
  logic                   w_line_inc;
  logic                   w_wait_done;
  logic                   w_m1;

`ifdef SHARP_EXTCOMIN_EN
  assign w_m1 = 1'b0;
  assign vcom = r_vcom_state;
`else
  assign w_m1 = r_vcom_state;
  assign vcom = 1'b0;
`endif

  assign w_frame_pend = r_frame_pend | frame_req;
  assign w_clear_pend = r_clear_pend | clear_req;
  assign w_wait_done  = !r_wait_first && !tx_busy;

  always_comb begin
    w_next         = r_state;
    w_accept_frame = 1'b0;
    w_accept_clear = 1'b0;
    w_fire_line    = 1'b0;
    w_fire_clear   = 1'b0;
    w_line_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clear_pend) begin
          w_accept_clear = 1'b1;
          w_next         = S_CLEAR_SEND;
        end else if (w_frame_pend) begin
          w_accept_frame = 1'b1;
          w_next         = S_FETCH;
        end
      end
      S_FETCH:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND: begin
        if (!tx_busy) begin
          w_fire_line = 1'b1;
          w_next      = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (w_wait_done) begin
          if (r_line == 8'(NUM_LINES)) begin
            w_next = S_DONE;
          end else begin
            w_line_inc = 1'b1;
            w_next     = S_FETCH;
          end
        end
      end
      S_CLEAR_SEND: begin
        if (!tx_busy) begin
          w_fire_clear = 1'b1;
          w_next       = S_CLEAR_WAIT;
        end
      end
      S_CLEAR_WAIT: begin
        if (w_wait_done) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_line       <= 8'd1;
      r_wait_first <= 1'b0;
      r_frame_pend <= 1'b0;
      r_clear_pend <= 1'b0;
      r_line_buf   <= '0;
    end else begin
      r_state      <= w_next;
      r_wait_first <= w_fire_line | w_fire_clear;
      r_frame_pend <= w_accept_frame ? 1'b0 : w_frame_pend;
      r_clear_pend <= w_accept_clear ? 1'b0 : w_clear_pend;
      if (w_accept_frame)
        r_line <= 8'd1;
      else if (w_line_inc)
        r_line <= r_line + 8'd1;
      if (r_state == S_CAPTURE)
        r_line_buf <= fb_data;
    end
  end

  // Captured line is staged and moved to tx_data only at tx_start, so the
  // payload never changes under a busy transmitter.
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      r_frame_busy <= 1'b0;
      r_frame_done <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_rd      <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_mode    <= '0;
      r_tx_addr    <= '0;
      r_tx_data    <= '0;
    end else begin
      r_fb_rd      <= (w_next == S_FETCH);
      r_tx_start   <= w_fire_line | w_fire_clear;
      r_frame_done <= (w_next == S_DONE);
      if (w_next == S_FETCH)
        r_fb_addr <= w_accept_frame ? 8'd0 : r_line;
      if (w_accept_frame || w_accept_clear)
        r_frame_busy <= 1'b1;
      else if (w_next == S_DONE)
        r_frame_busy <= 1'b0;
      if (w_fire_line) begin
        r_tx_mode <= {1'b0, w_m1, 1'b1};
        r_tx_addr <= r_line;
        r_tx_data <= r_line_buf;
      end else if (w_fire_clear) begin
        r_tx_mode <= {1'b1, w_m1, 1'b0};
        r_tx_addr <= '0;
        r_tx_data <= '0;
      end
    end
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      r_vcnt       <= '0;
      r_vcom_state <= 1'b0;
    end else if (r_vcnt == VW'(VCOM_DIV - 1)) begin
      r_vcnt       <= '0;
      r_vcom_state <= ~r_vcom_state;
    end else begin
      r_vcnt <= r_vcnt + 1'b1;
    end
  end

  assign frame_busy = r_frame_busy;
  assign frame_done = r_frame_done;
  assign fb_addr    = r_fb_addr;
  assign fb_rd      = r_fb_rd;
  assign tx_start   = r_tx_start;
  assign tx_mode    = r_tx_mode;
  assign tx_addr    = r_tx_addr;
  assign tx_data    = r_tx_data;

endmodule
